// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared constants and requester encoding for the RF write arbiter
package rf_arb_pkg;
  localparam int DATA_W = 512;
  localparam int NUM_REGS = 4;
  localparam int ADDR_W = 2;
  typedef enum logic {REQ_LD, REQ_ALU} req_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter; on conflict the requester not granted last wins
module rr_arb2
  import rf_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  req_e rr_last;
  always_comb gnt = (req == 2'b11) ? ((rr_last == REQ_LD) ? 2'b10 : 2'b01) : req;
  always_ff @(posedge clk) begin
    if (reset) rr_last <= REQ_LD;
    else if (gnt[REQ_ALU]) rr_last <= REQ_ALU;
    else if (gnt[REQ_LD]) rr_last <= REQ_LD;
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares both RF write ports between load unit and ALU pair; RF_ARB_STATS_EN adds grant/conflict counters
module rf_write_arbiter
  import rf_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr_lo,
  input  logic [ADDR_W-1:0] alu_addr_hi,
  input  logic [DATA_W-1:0] alu_data_lo,
  input  logic [DATA_W-1:0] alu_data_hi,
  output logic              rf_we1,
  output logic              rf_we2,
  output logic [ADDR_W-1:0] rf_waddr1,
  output logic [ADDR_W-1:0] rf_waddr2,
  output logic [DATA_W-1:0] rf_wdata1,
  output logic [DATA_W-1:0] rf_wdata2,
  output logic [NUM_REGS-1:0] pending,
  output logic              alu_addr_err
`ifdef RF_ARB_STATS_EN
  ,
  output logic [31:0]       stat_ld_grants,
  output logic [31:0]       stat_alu_grants,
  output logic [31:0]       stat_conflicts
`endif
);
  logic [1:0] gnt;
  logic       same;
  rr_arb2 u_arb (.clk(clk), .reset(reset), .req({alu_valid, ld_valid} & {2{~reset}}), .gnt(gnt));
  assign ld_ready = gnt[REQ_LD];
  assign alu_ready = gnt[REQ_ALU];
  assign same = alu_addr_lo == alu_addr_hi;
  assign pending = ({NUM_REGS{rf_we1}} & (NUM_REGS'(1) << rf_waddr1))
                 | ({NUM_REGS{rf_we2}} & (NUM_REGS'(1) << rf_waddr2));
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we1 <= 1'b0;
      rf_we2 <= 1'b0;
      rf_waddr1 <= '0;
      rf_waddr2 <= '0;
      rf_wdata1 <= '0;
      rf_wdata2 <= '0;
      alu_addr_err <= 1'b0;
    end else begin
      rf_we1 <= ld_ready | (alu_ready & ~same);
      rf_we2 <= alu_ready;
      alu_addr_err <= alu_ready & same;
      if (ld_ready) begin
        rf_waddr1 <= ld_addr;
        rf_wdata1 <= ld_data;
      end
      if (alu_ready) begin
        rf_waddr1 <= alu_addr_lo;
        rf_wdata1 <= alu_data_lo;
        rf_waddr2 <= alu_addr_hi;
        rf_wdata2 <= alu_data_hi;
      end
    end
  end
`ifdef RF_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ld_grants <= '0;
      stat_alu_grants <= '0;
      stat_conflicts <= '0;
    end else begin
      if (ld_ready && stat_ld_grants != '1) stat_ld_grants <= stat_ld_grants + 32'd1;
      if (alu_ready && stat_alu_grants != '1) stat_alu_grants <= stat_alu_grants + 32'd1;
      if (ld_valid && alu_valid && stat_conflicts != '1) stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: table-driven directed checks plus hand-written arbitration and reset sequences
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;
  logic clk = 1'b0;
  logic reset, ld_valid, alu_valid;
  logic ld_ready, alu_ready, rf_we1, rf_we2, alu_addr_err;
  logic [ADDR_W-1:0] ld_addr, alu_addr_lo, alu_addr_hi, rf_waddr1, rf_waddr2;
  logic [DATA_W-1:0] ld_data, alu_data_lo, alu_data_hi, rf_wdata1, rf_wdata2;
  logic [NUM_REGS-1:0] pending;
`ifdef RF_ARB_STATS_EN
  logic [31:0] stat_ld_grants, stat_alu_grants, stat_conflicts;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  rf_write_arbiter dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr_lo(alu_addr_lo), .alu_addr_hi(alu_addr_hi),
    .alu_data_lo(alu_data_lo), .alu_data_hi(alu_data_hi),
    .rf_we1(rf_we1), .rf_we2(rf_we2), .rf_waddr1(rf_waddr1), .rf_waddr2(rf_waddr2),
    .rf_wdata1(rf_wdata1), .rf_wdata2(rf_wdata2), .pending(pending), .alu_addr_err(alu_addr_err)
`ifdef RF_ARB_STATS_EN
    , .stat_ld_grants(stat_ld_grants), .stat_alu_grants(stat_alu_grants), .stat_conflicts(stat_conflicts)
`endif
  );
  typedef struct {
    logic ldv; logic [1:0] lda; logic [511:0] ldd;
    logic av; logic [1:0] lo; logic [1:0] hi; logic [511:0] dlo; logic [511:0] dhi;
    logic e_ldr; logic e_alr; logic e_we1; logic e_we2; logic chk1;
    logic [1:0] e_a1; logic [1:0] e_a2; logic [511:0] e_d1; logic [511:0] e_d2;
    logic [3:0] e_pend; logic e_err;
  } vec_t;
  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic idle();
    ld_valid = 1'b0;
    alu_valid = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  vec_t v[7];
  logic [511:0] da5, d0, d1, l3, e0, e1, f0, f1;
  initial begin
    da5 = {16{32'hA5A5A5A5}};
    d0 = {16{32'hD0D0D0D0}};
    d1 = {16{32'hD1D1D1D1}};
    l3 = {16{32'h33330000}};
    e0 = {16{32'hE0E0E0E0}};
    e1 = {16{32'hE1E1E1E1}};
    f0 = {16{32'hF0F0F0F0}};
    f1 = {16{32'hF1F1F1F1}};
    v[0] = '{1, 2, da5, 0, 0, 0, '0, '0, 1, 0, 1, 0, 1, 2, 0, da5, '0, 4'b0100, 0};
    v[1] = '{0, 0, '0, 1, 0, 1, d0, d1, 0, 1, 1, 1, 1, 0, 1, d0, d1, 4'b0011, 0};
    v[2] = '{1, 3, l3, 1, 2, 0, e0, e1, 1, 0, 1, 0, 1, 3, 1, l3, d1, 4'b1000, 0};
    v[3] = '{0, 3, l3, 1, 2, 0, e0, e1, 0, 1, 1, 1, 1, 2, 0, e0, e1, 4'b0101, 0};
    v[4] = '{0, 0, '0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 1, 2, 0, e0, e1, 4'b0000, 0};
    v[5] = '{0, 0, '0, 1, 3, 3, f0, f1, 0, 1, 0, 1, 0, 0, 3, '0, f1, 4'b1000, 1};
    v[6] = '{0, 0, '0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0, 0, 3, '0, f1, 4'b0000, 0};
    reset = 1'b1;
    idle();
    ld_addr = '0; ld_data = '0; alu_addr_lo = '0; alu_addr_hi = '0; alu_data_lo = '0; alu_data_hi = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_we1", DATA_W'(rf_we1), 0);
    chk("rst_we2", DATA_W'(rf_we2), 0);
    chk("rst_pending", DATA_W'(pending), 0);
    chk("rst_ld_ready", DATA_W'(ld_ready), 0);
    chk("rst_alu_ready", DATA_W'(alu_ready), 0);
    chk("rst_err", DATA_W'(alu_addr_err), 0);
`ifdef RF_ARB_STATS_EN
    chk("rst_stat_ld", DATA_W'(stat_ld_grants), 0);
    chk("rst_stat_alu", DATA_W'(stat_alu_grants), 0);
    chk("rst_stat_conf", DATA_W'(stat_conflicts), 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ld_valid = v[i].ldv; ld_addr = v[i].lda; ld_data = v[i].ldd;
      alu_valid = v[i].av; alu_addr_lo = v[i].lo; alu_addr_hi = v[i].hi;
      alu_data_lo = v[i].dlo; alu_data_hi = v[i].dhi;
      #1;
      chk($sformatf("v%0d_ld_ready", i), DATA_W'(ld_ready), DATA_W'(v[i].e_ldr));
      chk($sformatf("v%0d_alu_ready", i), DATA_W'(alu_ready), DATA_W'(v[i].e_alr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we1", i), DATA_W'(rf_we1), DATA_W'(v[i].e_we1));
      chk($sformatf("v%0d_we2", i), DATA_W'(rf_we2), DATA_W'(v[i].e_we2));
      if (v[i].chk1) begin
        chk($sformatf("v%0d_waddr1", i), DATA_W'(rf_waddr1), DATA_W'(v[i].e_a1));
        chk($sformatf("v%0d_wdata1", i), rf_wdata1, v[i].e_d1);
      end
      chk($sformatf("v%0d_waddr2", i), DATA_W'(rf_waddr2), DATA_W'(v[i].e_a2));
      chk($sformatf("v%0d_wdata2", i), rf_wdata2, v[i].e_d2);
      chk($sformatf("v%0d_pending", i), DATA_W'(pending), DATA_W'(v[i].e_pend));
      chk($sformatf("v%0d_err", i), DATA_W'(alu_addr_err), DATA_W'(v[i].e_err));
    end
    do_reset();
    ld_valid = 1'b1; ld_addr = 2'd0; ld_data = l3;
    alu_valid = 1'b1; alu_addr_lo = 2'd1; alu_addr_hi = 2'd2; alu_data_lo = e0; alu_data_hi = e1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_alu_ready", i), DATA_W'(alu_ready), DATA_W'(i % 2 == 0));
      chk($sformatf("rr%0d_ld_ready", i), DATA_W'(ld_ready), DATA_W'(i % 2 == 1));
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_we2", i), DATA_W'(rf_we2), DATA_W'(i % 2 == 0));
      chk($sformatf("rr%0d_pending", i), DATA_W'(pending), (i % 2 == 0) ? DATA_W'(4'b0110) : DATA_W'(4'b0001));
      @(negedge clk);
    end
    idle();
`ifdef RF_ARB_STATS_EN
    #1;
    chk("rr_stat_conf", DATA_W'(stat_conflicts), 4);
    chk("rr_stat_ld", DATA_W'(stat_ld_grants), 2);
    chk("rr_stat_alu", DATA_W'(stat_alu_grants), 2);
`endif
    @(negedge clk);
    alu_valid = 1'b1; alu_addr_lo = 2'd1; alu_addr_hi = 2'd2;
    @(posedge clk);
    #1;
    chk("mid_we1_before_rst", DATA_W'(rf_we1), 1);
    @(negedge clk);
    reset = 1'b1;
    ld_valid = 1'b1;
    #1;
    chk("rst_gates_ld_ready", DATA_W'(ld_ready), 0);
    @(posedge clk);
    #1;
    chk("mid_rst_we1", DATA_W'(rf_we1), 0);
    chk("mid_rst_we2", DATA_W'(rf_we2), 0);
    chk("mid_rst_pending", DATA_W'(pending), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_alu_wins", DATA_W'(alu_ready), 1);
    chk("post_rst_ld_loses", DATA_W'(ld_ready), 0);
    @(negedge clk);
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
